// File: rtl/srl_sra_seq_32bit.sv
// -----------------------------------------------------------------------------
// srl_sra_seq_32bit
//
// Multi-cycle 32-bit right shifter: logical (zero fill) or arithmetic (sign
// fill). A request is taken through a valid/ready handshake. The operand then
// shifts right by up to STEP bits per cycle, and the result is offered on a
// valid/ready response channel. This block trades latency for area on the
// right-shift path of the execute stage.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_ni       in   1   asynchronous reset, active-low
//   req_valid_i  in   1   request valid
//   req_ready_o  out  1   request can be accepted (IDLE only)
//   a_i          in  32   operand, sampled on the accept edge
//   shift_i      in   5   shift amount 0..31, sampled on the accept edge
//   arith_i      in   1   1 = sign fill, 0 = zero fill
//   rsp_valid_o  out  1   result valid (DONE)
//   rsp_ready_i  in   1   consumer accepts result
//   s_o          out 32   shifted result, straight from the data register
//   busy_o       out  1   operation in flight (SHIFT or DONE)
//
// Latency, with the accept edge counted as cycle 0:
//   shift_i = 0  -> rsp_valid_o high in cycle 1
//   shift_i = n  -> rsp_valid_o high in cycle 1 + ceil(n/STEP)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a request; req_ready_o high
// S_SHIFT | shifting r_data right by min(r_rem, STEP) each cycle
// S_DONE  | result on s_o, rsp_valid_o high until rsp_ready_i
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module srl_sra_seq_32bit #(
   parameter int STEP = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] a_i,
   input  logic [4:0]  shift_i,
   input  logic        arith_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] s_o,
   output logic        busy_o
);

   // Only power-of-two steps up to 16 are supported.
   if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
      $error("srl_sra_seq_32bit: STEP must be 1, 2, 4, 8 or 16");
   end

   localparam logic [4:0] STEP_AMT = 5'(STEP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_data;
   logic [31:0] w_data_nxt;
   logic [4:0]  r_rem;
   logic [4:0]  w_rem_nxt;
   logic        r_fill;
   logic        w_fill_nxt;

   logic        w_last;
   logic [4:0]  w_amt;
   logic [63:0] w_ext;
   logic [31:0] w_step_data;

   // The final step shifts by the leftover amount; every earlier step shifts
   // by a full STEP.
   assign w_last      = (r_rem <= STEP_AMT);
   assign w_amt       = w_last ? r_rem : STEP_AMT;

   // The fill bit is extended above the data word. After a right shift, the
   // low half then holds the data with the vacated MSBs already filled.
   assign w_ext       = {{32{r_fill}}, r_data};
   assign w_step_data = 32'(w_ext >> w_amt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_data  <= 32'h0;
         r_rem   <= 5'd0;
         r_fill  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_rem   <= w_rem_nxt;
         r_fill  <= w_fill_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_rem_nxt   = r_rem;
      w_fill_nxt  = r_fill;

      case (r_state)
         S_IDLE: begin
            if (req_valid_i) begin
               w_data_nxt  = a_i;
               w_rem_nxt   = shift_i;
               w_fill_nxt  = arith_i & a_i[31];
               w_state_nxt = (shift_i == 5'd0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_data_nxt = w_step_data;
            if (w_last) begin
               w_rem_nxt   = 5'd0;
               w_state_nxt = S_DONE;
            end else begin
               w_rem_nxt   = r_rem - STEP_AMT;
            end
         end
         S_DONE: begin
            if (rsp_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign req_ready_o = (r_state == S_IDLE);
   assign rsp_valid_o = (r_state == S_DONE);
   assign busy_o      = (r_state != S_IDLE);
   assign s_o         = r_data;

endmodule

// File: tb/tb_srl_sra_seq_32bit.sv
`timescale 1ns/1ps

module tb_srl_sra_seq_32bit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;
   int lanes_done = 0;
   bit dir_done = 1'b0;

   typedef struct {
      logic [31:0] s;
      int          due;
   } exp_t;

   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh, input bit ar);
      if (ar) return $signed(a) >>> sh;
      return a >> sh;
   endfunction

   function automatic int lat(input logic [4:0] sh, input int step);
      return (int'(sh) + step - 1) / step;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------------------------------------------------------- directed
   logic        rst_dir_n;
   logic        d_req_valid, d_req_ready, d_ar, d_rsp_valid, d_rsp_ready, d_busy;
   logic [31:0] d_a, d_s;
   logic [4:0]  d_sh;

   srl_sra_seq_32bit #(.STEP(4)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_dir_n),
      .req_valid_i (d_req_valid),
      .req_ready_o (d_req_ready),
      .a_i         (d_a),
      .shift_i     (d_sh),
      .arith_i     (d_ar),
      .rsp_valid_o (d_rsp_valid),
      .rsp_ready_i (d_rsp_ready),
      .s_o         (d_s),
      .busy_o      (d_busy)
   );

   exp_t        d_q[$];
   exp_t        d_e;
   bit          d_seen = 1'b0;
   bit          d_hs = 1'b0;
   logic [31:0] d_hold;

   always @(negedge clk) begin
      #2;
      if (!rst_dir_n) begin
         d_seen = 1'b0;
         d_hs   = 1'b0;
      end else begin
         if (d_hs) chk("d_valid_drop", 32'(d_rsp_valid), 32'd0);
         if (d_rsp_valid) begin
            chk("d_busy_in_done", 32'(d_busy), 32'd1);
            if (!d_seen) begin
               if (d_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL d_unexpected_rsp: got s=%h, expected no response", d_s);
               end else begin
                  d_e = d_q.pop_front();
                  chk("d_result", d_s, d_e.s);
                  chk("d_latency", 32'(cyc), 32'(d_e.due));
                  d_hold = d_s;
               end
               d_seen = 1'b1;
            end else begin
               chk("d_hold_stable", d_s, d_hold);
            end
         end else begin
            d_seen = 1'b0;
         end
         d_hs = d_rsp_valid && d_rsp_ready;
      end
   end

   task automatic d_issue(input logic [31:0] a, input logic [4:0] sh, input bit ar, input bit expect_rsp);
      int n;
      n = 0;
      d_a = a; d_sh = sh; d_ar = ar; d_req_valid = 1'b1;
      while (!d_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!d_req_ready) begin
         checks++;
         errors++;
         $display("FAIL d_accept_timeout: got req_ready=0, expected 1 within 50 cycles");
      end else if (expect_rsp) begin
         d_q.push_back('{ref_shift(a, sh, ar), cyc + 1 + lat(sh, 4)});
      end
      @(negedge clk);
      d_req_valid = 1'b0;
      d_a = $urandom; d_sh = 5'($urandom); d_ar = 1'($urandom);
   endtask

   task automatic d_wait_hs();
      int n;
      n = 0;
      while (!(d_rsp_valid && d_rsp_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!(d_rsp_valid && d_rsp_ready)) begin
         checks++;
         errors++;
         $display("FAIL d_rsp_timeout: got no handshake, expected one within 100 cycles");
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst_dir_n = 1'b0;
      d_req_valid = 1'b0; d_a = '0; d_sh = '0; d_ar = 1'b0; d_rsp_ready = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(d_req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(d_rsp_valid), 32'd0);
      chk("rst_busy", 32'(d_busy), 32'd0);
      chk("rst_s", d_s, 32'h0);
      @(negedge clk);
      rst_dir_n = 1'b1;
      @(negedge clk);

      // ready held high before DONE; basic shifts and zero shift
      d_rsp_ready = 1'b1;
      d_issue(32'hF000_0000, 5'd4, 1'b0, 1'b1);
      d_wait_hs();
      d_issue(32'h8000_0000, 5'd31, 1'b1, 1'b1);
      d_wait_hs();
      d_issue(32'h8000_0000, 5'd31, 1'b0, 1'b1);
      d_wait_hs();
      d_issue(32'h1234_5678, 5'd0, 1'b0, 1'b1);
      d_wait_hs();

      // backpressure while a new request is pending
      d_rsp_ready = 1'b0;
      d_issue(32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1);
      n = 0;
      while (!d_rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      d_a = 32'hCAFE_F00D; d_sh = 5'd3; d_ar = 1'b0; d_req_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_req_ready_low", 32'(d_req_ready), 32'd0);
         chk("bp_rsp_valid_high", 32'(d_rsp_valid), 32'd1);
      end
      d_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_not_accepted_in_hs", 32'(d_busy), 32'd0);
      chk("bp_req_ready_after_hs", 32'(d_req_ready), 32'd1);
      d_q.push_back('{ref_shift(32'hCAFE_F00D, 5'd3, 1'b0), cyc + 1 + lat(5'd3, 4)});
      @(negedge clk);
      chk("bp_accepted_next", 32'(d_busy), 32'd1);
      d_req_valid = 1'b0;
      d_wait_hs();

      // reset in the middle of a shift; no response may come out
      d_issue(32'hFFFF_0000, 5'd20, 1'b1, 1'b0);
      @(negedge clk);
      chk("mid_busy_before_rst", 32'(d_busy), 32'd1);
      rst_dir_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", 32'(d_rsp_valid), 32'd0);
      chk("mid_rst_s", d_s, 32'h0);
      chk("mid_rst_req_ready", 32'(d_req_ready), 32'd1);
      chk("mid_rst_busy", 32'(d_busy), 32'd0);
      @(negedge clk);
      rst_dir_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_rsp_valid", 32'(d_rsp_valid), 32'd0);
      chk("post_rst_req_ready", 32'(d_req_ready), 32'd1);
      d_issue(32'h7FFF_FFFF, 5'd5, 1'b1, 1'b1);
      d_wait_hs();
      chk("d_queue_empty", 32'(d_q.size()), 32'd0);
      dir_done = 1'b1;
   end

   // ----------------------------------------------- exhaustive lanes per STEP
   logic rst_n;

   for (genvar g = 0; g < 3; g++) begin : g_lane
      localparam int LS = (g == 0) ? 1 : ((g == 1) ? 4 : 16);

      logic        req_valid, req_ready, ar, rsp_valid, rsp_ready, busy;
      logic [31:0] a, s;
      logic [4:0]  sh;

      srl_sra_seq_32bit #(.STEP(LS)) u_lane (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .req_valid_i (req_valid),
         .req_ready_o (req_ready),
         .a_i         (a),
         .shift_i     (sh),
         .arith_i     (ar),
         .rsp_valid_o (rsp_valid),
         .rsp_ready_i (rsp_ready),
         .s_o         (s),
         .busy_o      (busy)
      );

      exp_t        q[$];
      exp_t        e;
      bit          seen = 1'b0;
      bit          hs = 1'b0;
      logic [31:0] hold;

      always @(negedge clk) begin
         #2;
         if (!rst_n) begin
            seen = 1'b0;
            hs   = 1'b0;
         end else begin
            if (hs) chk($sformatf("step%0d_valid_drop", LS), 32'(rsp_valid), 32'd0);
            if (rsp_valid) begin
               chk($sformatf("step%0d_busy", LS), 32'(busy), 32'd1);
               if (!seen) begin
                  if (q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL step%0d_unexpected_rsp: got s=%h, expected no response", LS, s);
                  end else begin
                     e = q.pop_front();
                     chk($sformatf("step%0d_result", LS), s, e.s);
                     chk($sformatf("step%0d_latency", LS), 32'(cyc), 32'(e.due));
                     hold = s;
                  end
                  seen = 1'b1;
               end else begin
                  chk($sformatf("step%0d_hold_stable", LS), s, hold);
               end
            end else begin
               seen = 1'b0;
            end
            hs = rsp_valid && rsp_ready;
         end
      end

      initial begin
         int k;
         req_valid = 1'b0; a = '0; sh = '0; ar = 1'b0; rsp_ready = 1'b0;
         @(posedge rst_n);
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 32; n++) begin
               a = $urandom; sh = 5'(n); ar = m[0]; req_valid = 1'b1;
               k = 0;
               while (!req_ready && k < 100) begin
                  rsp_ready = 1'($urandom);
                  @(negedge clk);
                  k++;
               end
               if (!req_ready) begin
                  checks++;
                  errors++;
                  $display("FAIL step%0d_accept_timeout: got req_ready=0, expected 1", LS);
               end else begin
                  q.push_back('{ref_shift(a, 5'(n), m[0]), cyc + 1 + lat(5'(n), LS)});
               end
               @(negedge clk);
               req_valid = 1'b0; a = $urandom; sh = 5'($urandom); ar = 1'($urandom);
               k = 0;
               rsp_ready = 1'($urandom);
               while (!(rsp_valid && rsp_ready) && k < 100) begin
                  @(negedge clk);
                  rsp_ready = 1'($urandom);
                  k++;
               end
               if (!(rsp_valid && rsp_ready)) begin
                  checks++;
                  errors++;
                  $display("FAIL step%0d_rsp_timeout: got no handshake, expected one", LS);
               end
               @(negedge clk);
            end
         end
         lanes_done++;
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50000; i++) begin
         if (lanes_done == 3 && dir_done) break;
         @(negedge clk);
      end
      if (!(lanes_done == 3 && dir_done)) begin
         checks++;
         errors++;
         $display("FAIL global_timeout: got lanes_done=%0d dir_done=%0d, expected 3 and 1", lanes_done, dir_done);
      end
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
